// File: rtl/radix4_online_pkg.sv
// Shared helpers for the radix-4 online arithmetic datapath: residual sizing,
// digit slicing and the signed-digit top-digit fold.
package radix4_online_pkg;

    typedef struct packed {
        logic [7:0] d2;
        logic       folded;
        logic       overflow;
    } fold_t;

    function automatic int nd_digits(input int no_of_digits, input int delta);
        return no_of_digits + delta + 1;
    endfunction

    function automatic int w_bits(input int no_of_digits, input int delta, input int radix_bits);
        return radix_bits * nd_digits(no_of_digits, delta);
    endfunction

    function automatic int digit_lsb(input int k, input int radix_bits);
        return k * radix_bits;
    endfunction

    // Digits arrive sign-extended to 8 bits; the caller truncates d2 back to
    // its digit width, so an out-of-range fold wraps rather than saturates.
    function automatic fold_t fold_digit_pair(input logic signed [7:0] d1,
                                              input logic signed [7:0] d2,
                                              input int radix);
        fold_t r;
        r.d2       = d2;
        r.folded   = 1'b0;
        r.overflow = 1'b0;
        if (d1 == 8'sd1) begin
            r.d2     = d2 + 8'(radix);
            r.folded = 1'b1;
        end else if (d1 == -8'sd1) begin
            r.d2     = d2 - 8'(radix);
            r.folded = 1'b1;
        end else if (d1 != 8'sd0) begin
            r.overflow = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_arbiter.sv
// Round-robin priority search: first requester at or after ptr wins, modulo num_req.
module rr_priority_arbiter #(
    parameter int num_req = 4,
    localparam int IDW = $clog2(num_req)
) (
    input  logic [num_req-1:0] req,
    input  logic [IDW-1:0]     ptr,
    input  logic               enable,
    output logic [num_req-1:0] grant,
    output logic [IDW-1:0]     grant_idx,
    output logic               grant_valid
);

    logic [IDW-1:0] cand_idx [num_req];

    generate
        for (genvar gi = 0; gi < num_req; gi++) begin : g_cand
            logic [IDW:0] sum;
            assign sum = {1'b0, ptr} + (IDW+1)'(gi);
            assign cand_idx[gi] = (sum >= (IDW+1)'(num_req)) ?
                                  IDW'(sum - (IDW+1)'(num_req)) : IDW'(sum);
        end
    endgenerate

    logic found;

    // Scan from the far end so the candidate closest to ptr wins last.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        found       = 1'b0;
        for (int k = num_req - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                grant_idx = cand_idx[k];
                found     = 1'b1;
            end
        end
        grant_valid = found && enable;
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/radix4_wmod_arbiter.sv
// Shared residual fold unit: round-robin picks one requester per cycle and
// returns its folded residual through a single registered, id-tagged response.
module radix4_wmod_arbiter
    import radix4_online_pkg::*;
#(
    parameter int no_of_digits = 4,
    parameter int radix_bits   = 3,
    parameter int radix        = 4,
    parameter int delta        = 2,
    parameter int num_req      = 4,
    localparam int ND  = nd_digits(no_of_digits, delta),
    localparam int W   = w_bits(no_of_digits, delta, radix_bits),
    localparam int IDW = $clog2(num_req)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [num_req-1:0]   req_valid,
    output logic [num_req-1:0]   req_ready,
    input  logic [num_req*W-1:0] req_w,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [W-1:0]         rsp_w,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_folded,
    output logic                 rsp_overflow
);

    localparam int D1_LSB = digit_lsb(ND - 1, radix_bits);
    localparam int D2_LSB = digit_lsb(ND - 2, radix_bits);

    logic                 rsp_valid_reg;
    logic [W-1:0]         rsp_w_reg;
    logic [IDW-1:0]       rsp_id_reg;
    logic                 rsp_folded_reg;
    logic                 rsp_overflow_reg;
    logic [IDW-1:0]       ptr_reg;

    logic                 slot_free;
    logic [num_req-1:0]   grant;
    logic [IDW-1:0]       grant_idx;
    logic                 grant_valid;

    assign slot_free = !rsp_valid_reg || rsp_ready;

    rr_priority_arbiter #(.num_req(num_req)) u_arb (
        .req         (req_valid),
        .ptr         (ptr_reg),
        .enable      (slot_free),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign req_ready = grant;

    logic [W-1:0]            sel_w;
    logic [radix_bits-1:0]   d1_raw;
    logic [radix_bits-1:0]   d2_raw;
    logic signed [7:0]       d1_ext;
    logic signed [7:0]       d2_ext;
    fold_t                   fold_res;
    logic [W-1:0]            folded_w;

    assign sel_w  = req_w[grant_idx*W +: W];
    assign d1_raw = sel_w[D1_LSB +: radix_bits];
    assign d2_raw = sel_w[D2_LSB +: radix_bits];
    assign d1_ext = 8'(signed'(d1_raw));
    assign d2_ext = 8'(signed'(d2_raw));

    always_comb begin
        fold_res = fold_digit_pair(d1_ext, d2_ext, radix);
        folded_w = sel_w;
        if (fold_res.folded) begin
            folded_w[D1_LSB +: radix_bits] = '0;
            folded_w[D2_LSB +: radix_bits] = radix_bits'(fold_res.d2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_reg    <= 1'b0;
            rsp_w_reg        <= '0;
            rsp_id_reg       <= '0;
            rsp_folded_reg   <= 1'b0;
            rsp_overflow_reg <= 1'b0;
            ptr_reg          <= '0;
        end else if (grant_valid) begin
            rsp_valid_reg    <= 1'b1;
            rsp_w_reg        <= folded_w;
            rsp_id_reg       <= grant_idx;
            rsp_folded_reg   <= fold_res.folded;
            rsp_overflow_reg <= fold_res.overflow;
            ptr_reg          <= (grant_idx == IDW'(num_req - 1)) ? '0 : grant_idx + IDW'(1);
        end else if (rsp_ready) begin
            rsp_valid_reg    <= 1'b0;
        end
    end

    assign rsp_valid    = rsp_valid_reg;
    assign rsp_w        = rsp_w_reg;
    assign rsp_id       = rsp_id_reg;
    assign rsp_folded   = rsp_folded_reg;
    assign rsp_overflow = rsp_overflow_reg;

endmodule

// File: tb/tb_radix4_wmod_arbiter.sv
// Directed bench for radix4_wmod_arbiter: fold cases, round-robin order,
// backpressure, reset mid-operation and a single sparse requester.
module tb_radix4_wmod_arbiter;

    localparam int N = 4;
    localparam int W = 21;
    localparam logic [14:0] LOW = 15'h2a5a;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_w;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_w;
    logic [1:0]       rsp_id;
    logic             rsp_folded;
    logic             rsp_overflow;

    int compared   = 0;
    int mismatched = 0;

    radix4_wmod_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_w        (req_w),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_w        (rsp_w),
        .rsp_id       (rsp_id),
        .rsp_folded   (rsp_folded),
        .rsp_overflow (rsp_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [2:0] d1, input logic [2:0] d2,
                                        input logic [14:0] low);
        return {d1, d2, low};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        compared++;
        assert (obs === want) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [W-1:0] rr_w [N];
    logic [W-1:0] f_in   [5];
    logic [W-1:0] f_want [5];
    logic         f_fold [5];
    logic         f_ovf  [5];

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_w     = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        check("reset_valid", 32'(rsp_valid), 0);
        check("reset_w", 32'(rsp_w), 0);
        check("reset_id", 32'(rsp_id), 0);
        check("reset_folded", 32'(rsp_folded), 0);
        check("reset_ovf", 32'(rsp_overflow), 0);
        reset = 1'b0;
        #1;
        check("idle_ready", 32'(req_ready), 0);

        // Fold +1: d1=001, d2=110 (-2) -> d2=010
        req_w[0*W +: W] = mk(3'b001, 3'b110, LOW);
        req_valid = 4'b0001;
        #1;
        check("fp1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("fp1_valid", 32'(rsp_valid), 1);
        check("fp1_w", 32'(rsp_w), 32'(mk(3'b000, 3'b010, LOW)));
        check("fp1_id", 32'(rsp_id), 0);
        check("fp1_folded", 32'(rsp_folded), 1);
        check("fp1_ovf", 32'(rsp_overflow), 0);
        tick();
        check("drain_valid", 32'(rsp_valid), 0);

        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Round-robin with all requesters valid
        for (int i = 0; i < N; i++) begin
            rr_w[i] = mk(3'b000, 3'(i), 15'(i * 100 + 7));
            req_w[i*W +: W] = rr_w[i];
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            check($sformatf("rr_valid_%0d", k), 32'(rsp_valid), 1);
            check($sformatf("rr_id_%0d", k), 32'(rsp_id), 32'(k % 4));
            check($sformatf("rr_w_%0d", k), 32'(rsp_w), 32'(rr_w[k % 4]));
        end

        // Backpressure: response for req 0 pending, pointer at 1
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_ready_%0d", k), 32'(req_ready), 0);
            tick();
            check($sformatf("bp_valid_%0d", k), 32'(rsp_valid), 1);
            check($sformatf("bp_id_%0d", k), 32'(rsp_id), 0);
            check($sformatf("bp_w_%0d", k), 32'(rsp_w), 32'(rr_w[0]));
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'h2);
        tick();
        check("bp_release_id", 32'(rsp_id), 1);

        // Fold -1 / overflow / wrap through requester 3, others hold junk
        f_in[0] = mk(3'b111, 3'b001, LOW); f_want[0] = mk(3'b000, 3'b101, LOW); f_fold[0] = 1; f_ovf[0] = 0;
        f_in[1] = mk(3'b010, 3'b011, LOW); f_want[1] = f_in[1];                 f_fold[1] = 0; f_ovf[1] = 1;
        f_in[2] = mk(3'b001, 3'b011, LOW); f_want[2] = mk(3'b000, 3'b111, LOW); f_fold[2] = 1; f_ovf[2] = 0;
        f_in[3] = mk(3'b000, 3'b101, LOW); f_want[3] = f_in[3];                 f_fold[3] = 0; f_ovf[3] = 0;
        f_in[4] = mk(3'b100, 3'b010, LOW); f_want[4] = f_in[4];                 f_fold[4] = 0; f_ovf[4] = 1;
        req_w[0*W +: W] = mk(3'b001, 3'b001, 15'h7fff);
        req_w[1*W +: W] = mk(3'b111, 3'b111, 15'h0001);
        req_valid = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            req_w[3*W +: W] = f_in[k];
            #1;
            check($sformatf("fold_ready_%0d", k), 32'(req_ready), 32'h8);
            tick();
            check($sformatf("fold_id_%0d", k), 32'(rsp_id), 3);
            check($sformatf("fold_w_%0d", k), 32'(rsp_w), 32'(f_want[k]));
            check($sformatf("fold_folded_%0d", k), 32'(rsp_folded), 32'(f_fold[k]));
            check($sformatf("fold_ovf_%0d", k), 32'(rsp_overflow), 32'(f_ovf[k]));
        end

        // Reset mid-operation with ptr=2 and a response pending
        req_valid = 4'b0010;
        #1;
        check("rm_ready", 32'(req_ready), 32'h2);
        tick();
        check("rm_pending_id", 32'(rsp_id), 1);
        reset = 1'b1;
        req_valid = 4'b1111;
        tick();
        check("rm_valid", 32'(rsp_valid), 0);
        check("rm_w", 32'(rsp_w), 0);
        check("rm_id", 32'(rsp_id), 0);
        check("rm_folded", 32'(rsp_folded), 0);
        check("rm_ovf", 32'(rsp_overflow), 0);
        reset = 1'b0;
        #1;
        check("rm_first_grant", 32'(req_ready), 32'h1);
        tick();
        check("rm_first_id", 32'(rsp_id), 0);

        // Sparse: only requester 2, continuous output
        req_w[2*W +: W] = mk(3'b001, 3'b000, LOW);
        req_valid = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("sp_ready_%0d", k), 32'(req_ready), 32'h4);
            tick();
            check($sformatf("sp_valid_%0d", k), 32'(rsp_valid), 1);
            check($sformatf("sp_id_%0d", k), 32'(rsp_id), 2);
            check($sformatf("sp_w_%0d", k), 32'(rsp_w), 32'(mk(3'b000, 3'b100, LOW)));
        end
        req_valid = '0;
        tick();
        check("final_drain", 32'(rsp_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
